// File: rtl/gps_time_counter.sv
// ---------------------------------------------------------------------------
// gps_time_counter
//
// Free-running calendar / time-of-day source for the GPS timestamp latch.
// The GPS message decoder loads an absolute time, and the receiver PPS pulse
// keeps it aligned. The counter advances one microsecond every CLKS_PER_US
// clocks. Carries ripple through ms, s, min, h, day, month and year within
// a single cycle.
//
// Parameters
//   CLKS_PER_US   clk cycles per microsecond (>= 2)
//
// Ports
//   clk            in   1   system clock, all logic on posedge
//   reset          in   1   asynchronous active-high reset
//   load           in   1   1-cycle strobe: take *_in fields as current time
//   year_in        in  12   full year (e.g. 2024)
//   month_in       in   4   1..12
//   day_in         in   5   1..31
//   hour_in        in   5   0..23
//   minute_in      in   6   0..59
//   second_in      in   6   0..59
//   millisec_in    in  10   0..999
//   microsec_in    in  10   0..999
//   pps            in   1   1-cycle pulse on a whole GPS second (clk domain)
//   year_out ..
//   microsec_out   out      registered current time, same widths as *_in
//   time_valid     out  1   set by the first load, cleared only by reset
//   us_tick        out  1   high in the cycle a new microsecond value appears
//
// Event priority: reset > load > pps > prescaler tick.
// ---------------------------------------------------------------------------
module gps_time_counter #(
    parameter int CLKS_PER_US = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] year_in,
    input  logic [3:0]  month_in,
    input  logic [4:0]  day_in,
    input  logic [4:0]  hour_in,
    input  logic [5:0]  minute_in,
    input  logic [5:0]  second_in,
    input  logic [9:0]  millisec_in,
    input  logic [9:0]  microsec_in,
    input  logic        pps,
    output logic [11:0] year_out,
    output logic [3:0]  month_out,
    output logic [4:0]  day_out,
    output logic [4:0]  hour_out,
    output logic [5:0]  minute_out,
    output logic [5:0]  second_out,
    output logic [9:0]  millisec_out,
    output logic [9:0]  microsec_out,
    output logic        time_valid,
    output logic        us_tick
);

    localparam int              PW         = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_US - 1);

    // -----------------------------------------------------------------------
    // Month length. Leap rule is the simple year % 4 test. That test is exact
    // for 2001..2099, which covers the operating range. Month codes outside
    // 1..12 fall into the 31-day default, so a bad load still rolls over.
    // -----------------------------------------------------------------------
    function automatic logic [4:0] days_in_month(input logic [3:0] mon,
                                                 input logic [11:0] yr);
        logic [4:0] dim;
        case (mon)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
        return dim;
    endfunction

    logic [PW-1:0] prescaler;
    logic          presc_done;
    logic          tick;       // microsecond advance this cycle
    logic          pps_take;   // pps honoured this cycle (no competing load)
    logic [4:0]    dim_now;

    // Carry enables. Each one means "this field increments or wraps now".
    logic inc_ms;
    logic inc_sec;
    logic inc_min;
    logic inc_hour;
    logic inc_day;
    logic inc_month;
    logic inc_year;

    assign presc_done = (prescaler == PRESC_LAST);
    assign tick       = presc_done && !load && !pps;
    assign pps_take   = pps && !load;
    assign dim_now    = days_in_month(month_out, year_out);

    // -----------------------------------------------------------------------
    // Carry chain. Every wrap test uses >=, not ==, so an out-of-range value
    // (for example second=63 from an unchecked load) wraps on its next
    // increment. Otherwise it would count up to the field's bit width.
    // A pps that arrives with ms >= 500 is early: the local second has not
    // rolled yet, so the pps injects the seconds carry itself. A pps with
    // ms < 500 is late: the second already rolled, so it only zeroes ms/us.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a
        // missing default would infer a latch.
        inc_ms    = 1'b0;
        inc_sec   = 1'b0;
        inc_min   = 1'b0;
        inc_hour  = 1'b0;
        inc_day   = 1'b0;
        inc_month = 1'b0;
        inc_year  = 1'b0;

        inc_ms    = tick && (microsec_out >= 10'd999);
        inc_sec   = (inc_ms && (millisec_out >= 10'd999)) ||
                    (pps_take && (millisec_out >= 10'd500));
        inc_min   = inc_sec   && (second_out >= 6'd59);
        inc_hour  = inc_min   && (minute_out >= 6'd59);
        inc_day   = inc_hour  && (hour_out   >= 5'd23);
        inc_month = inc_day   && (day_out    >= dim_now);
        inc_year  = inc_month && (month_out  >= 4'd12);
    end

    // -----------------------------------------------------------------------
    // State registers. reset is expected to be released synchronously to
    // clk by the reset tree. Assertion takes effect immediately, mid-count.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // fields update from the same pre-edge values.
        if (reset) begin
            prescaler    <= '0;
            year_out     <= 12'd0;
            month_out    <= 4'd1;
            day_out      <= 5'd1;
            hour_out     <= 5'd0;
            minute_out   <= 6'd0;
            second_out   <= 6'd0;
            millisec_out <= 10'd0;
            microsec_out <= 10'd0;
            time_valid   <= 1'b0;
            us_tick      <= 1'b0;
        end else if (load) begin
            // Absolute time from the decoder is taken as-is. A simultaneous
            // pps is dropped, because the loaded value is already aligned.
            prescaler    <= '0;
            year_out     <= year_in;
            month_out    <= month_in;
            day_out      <= day_in;
            hour_out     <= hour_in;
            minute_out   <= minute_in;
            second_out   <= second_in;
            millisec_out <= millisec_in;
            microsec_out <= microsec_in;
            time_valid   <= 1'b1;
            us_tick      <= 1'b0;
        end else begin
            // pps restarts the sub-microsecond phase as well.
            if (pps_take || presc_done) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (pps_take) begin
                microsec_out <= 10'd0;
            end else if (tick) begin
                microsec_out <= (microsec_out >= 10'd999) ? 10'd0 : microsec_out + 10'd1;
            end

            if (pps_take) begin
                millisec_out <= 10'd0;
            end else if (inc_ms) begin
                millisec_out <= (millisec_out >= 10'd999) ? 10'd0 : millisec_out + 10'd1;
            end

            if (inc_sec) begin
                second_out <= (second_out >= 6'd59) ? 6'd0 : second_out + 6'd1;
            end

            if (inc_min) begin
                minute_out <= (minute_out >= 6'd59) ? 6'd0 : minute_out + 6'd1;
            end

            if (inc_hour) begin
                hour_out <= (hour_out >= 5'd23) ? 5'd0 : hour_out + 5'd1;
            end

            // Days and months are 1-based, so they wrap to 1, not 0.
            if (inc_day) begin
                day_out <= (day_out >= dim_now) ? 5'd1 : day_out + 5'd1;
            end

            if (inc_month) begin
                month_out <= (month_out >= 4'd12) ? 4'd1 : month_out + 4'd1;
            end

            // Year wraps 4095 -> 0 through the natural 12-bit overflow.
            if (inc_year) begin
                year_out <= year_out + 12'd1;
            end

            us_tick <= tick;
        end
    end

endmodule
